// File: rtl/tile_frame_renderer.sv
// rtl/tile_frame_renderer.sv - double-buffered solid-colour tile renderer with registered VGA outputs
module tile_frame_renderer #(
  parameter int COORD_WIDTH = 10,
  parameter int COLOR_BITS  = 4,
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int TILE_SHIFT  = 5,
  parameter int ORIGIN_X    = 192,
  parameter int ORIGIN_Y    = 112,
  parameter logic [3*COLOR_BITS-1:0] BG_RGB = '0,
  parameter logic SYNC_POL  = 1'b0,
  localparam int N     = GRID_W * GRID_H,
  localparam int AW    = $clog2(N),
  localparam int RGB_W = 3 * COLOR_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_pix_en,
  input  logic [COORD_WIDTH-1:0] i_sx,
  input  logic [COORD_WIDTH-1:0] i_sy,
  input  logic                   i_de,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [RGB_W-1:0]       i_wr_rgb,
  input  logic                   i_commit,
  output logic                   o_commit_pending,
  output logic                   o_frame_start,
  output logic [COLOR_BITS-1:0]  o_r,
  output logic [COLOR_BITS-1:0]  o_g,
  output logic [COLOR_BITS-1:0]  o_b,
  output logic                   o_hsync,
  output logic                   o_vsync
);

  localparam logic [COORD_WIDTH-1:0] X_LO = COORD_WIDTH'(ORIGIN_X);
  localparam logic [COORD_WIDTH-1:0] X_HI = COORD_WIDTH'(ORIGIN_X + (GRID_W << TILE_SHIFT));
  localparam logic [COORD_WIDTH-1:0] Y_LO = COORD_WIDTH'(ORIGIN_Y);
  localparam logic [COORD_WIDTH-1:0] Y_HI = COORD_WIDTH'(ORIGIN_Y + (GRID_H << TILE_SHIFT));

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_COPY} state_t;

  state_t            state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              vs_prev_q, vs_prev_d;

  logic              inside_q, inside_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              de1_q, de1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;

  // Banks power up zero and are deliberately excluded from reset.
  logic [RGB_W-1:0]  bank0_q [N] = '{default: '0};
  logic [RGB_W-1:0]  bank1_q [N] = '{default: '0};

  logic              we_back, mem_we0, mem_we1;
  logic [AW-1:0]     mem_waddr;
  logic [RGB_W-1:0]  mem_wdata;
  logic [RGB_W-1:0]  front_rd, copy_rd;
  logic [COORD_WIDTH-1:0] dx, dy;
  logic              wr_in_range;

  assign front_rd      = front_sel_q ? bank1_q[addr_q] : bank0_q[addr_q];
  assign copy_rd       = front_sel_q ? bank1_q[cnt_q] : bank0_q[cnt_q];
  assign wr_in_range   = ({1'b0, i_wr_addr} < (AW+1)'(N));
  assign o_frame_start = i_rst_n && i_pix_en && (i_vsync == SYNC_POL) && (vs_prev_q != SYNC_POL);
  assign mem_we0       = i_rst_n && we_back && front_sel_q;
  assign mem_we1       = i_rst_n && we_back && !front_sel_q;

  always_comb begin
    state_d          = state_q;
    front_sel_d      = front_sel_q;
    cnt_d            = cnt_q;
    o_wr_ready       = 1'b0;
    o_commit_pending = 1'b0;
    we_back          = 1'b0;
    mem_waddr        = i_wr_addr;
    mem_wdata        = i_wr_rgb;
    case (state_q)
      ST_IDLE: begin
        o_wr_ready = 1'b1;
        we_back    = i_wr_valid && wr_in_range;
        if (i_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        o_commit_pending = 1'b1;
        if (o_frame_start) begin
          front_sel_d = ~front_sel_q;
          cnt_d       = '0;
          state_d     = ST_COPY;
        end
      end
      ST_COPY: begin
        we_back   = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = copy_rd;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AW'(N - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dx         = i_sx - X_LO;
    dy         = i_sy - Y_LO;
    vs_prev_d  = vs_prev_q;
    inside_d   = inside_q;
    addr_d     = addr_q;
    de1_d      = de1_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    rgb_d      = rgb_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    if (i_pix_en) begin
      vs_prev_d = i_vsync;
      inside_d  = (i_sx >= X_LO) && (i_sx < X_HI) && (i_sy >= Y_LO) && (i_sy < Y_HI);
      addr_d    = AW'((dy >> TILE_SHIFT) * COORD_WIDTH'(GRID_W) + (dx >> TILE_SHIFT));
      de1_d     = i_de;
      hs1_d     = i_hsync;
      vs1_d     = i_vsync;
      if (!de1_q)       rgb_d = '0;
      else if (inside_q) rgb_d = front_rd;
      else              rgb_d = BG_RGB;
      hs_d      = hs1_q;
      vs_d      = vs1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      cnt_q       <= '0;
      vs_prev_q   <= ~SYNC_POL;
      inside_q    <= 1'b0;
      addr_q      <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= ~SYNC_POL;
      vs1_q       <= ~SYNC_POL;
      rgb_q       <= '0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      cnt_q       <= cnt_d;
      vs_prev_q   <= vs_prev_d;
      inside_q    <= inside_d;
      addr_q      <= addr_d;
      de1_q       <= de1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we0) bank0_q[mem_waddr] <= mem_wdata;
    if (mem_we1) bank1_q[mem_waddr] <= mem_wdata;
  end

  assign o_r     = rgb_q[RGB_W-1 -: COLOR_BITS];
  assign o_g     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign o_b     = rgb_q[COLOR_BITS-1:0];
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;

endmodule

// File: tb/tb_tile_frame_renderer.sv
// tb/tb_tile_frame_renderer.sv - self-checking bench for tile_frame_renderer
module tb_tile_frame_renderer;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pix_en, de, hs, vs, wr_valid, wr_ready, commit, pending, fstart;
  logic [9:0]  sx, sy;
  logic [5:0]  wr_addr;
  logic [11:0] wr_rgb;
  logic [3:0]  r, g, b;
  logic        ohs, ovs;

  tile_frame_renderer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_sx(sx), .i_sy(sy),
    .i_de(de), .i_hsync(hs), .i_vsync(vs), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_rgb(wr_rgb), .i_commit(commit), .o_commit_pending(pending),
    .o_frame_start(fstart), .o_r(r), .o_g(g), .o_b(b), .o_hsync(ohs), .o_vsync(ovs)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: banks, which bank is displayed, and the commit/copy progress.
  logic [11:0] m_bank [2][N];
  int m_front = 0, m_state = 0, m_copy_idx = 0, m_prev_vs = 1;
  int s1_sx = 0, s1_sy = 0, s1_de = 0, s1_hs = 1, s1_vs = 1;
  logic [11:0] e_rgb = '0;
  int e_hs = 1, e_vs = 1;

  typedef struct {
    int x; int y; int d; int h;
    logic [11:0] rgb;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] colour(input int x, input int y, input int d, input int f);
    if (d == 0) return 12'h000;
    if (x >= 192 && x < 448 && y >= 112 && y < 368)
      return m_bank[f][((y - 112) / 32) * 8 + (x - 192) / 32];
    return 12'h000;
  endfunction

  task automatic cycle();
    int old_front;
    @(negedge clk);
    if (rst_n) begin
      chk("wr_ready", wr_ready, m_state == 0);
      chk("commit_pending", pending, m_state == 1);
      chk("frame_start", fstart, pix_en && vs == 0 && m_prev_vs == 1);
      chk("rgb", {r, g, b}, e_rgb);
      chk("hsync_out", ohs, e_hs);
      chk("vsync_out", ovs, e_vs);
    end
    if (!rst_n) begin
      m_state = 0; m_front = 0; m_prev_vs = 1;
      s1_de = 0; s1_hs = 1; s1_vs = 1; e_rgb = '0; e_hs = 1; e_vs = 1;
    end else begin
      old_front = m_front;
      case (m_state)
        0: begin
          if (wr_valid && int'(wr_addr) < N) m_bank[1 - m_front][wr_addr] = wr_rgb;
          if (commit) m_state = 1;
        end
        1: if (pix_en && vs == 0 && m_prev_vs == 1) begin
          m_front = 1 - m_front; m_copy_idx = 0; m_state = 2;
        end
        default: begin
          m_bank[1 - m_front][m_copy_idx] = m_bank[m_front][m_copy_idx];
          m_copy_idx++;
          if (m_copy_idx == N) m_state = 0;
        end
      endcase
      if (pix_en) begin
        e_rgb = colour(s1_sx, s1_sy, s1_de, old_front);
        e_hs = s1_hs; e_vs = s1_vs;
        s1_sx = sx; s1_sy = sy; s1_de = de; s1_hs = hs; s1_vs = vs;
        m_prev_vs = vs;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int x, input int y, input int d, input int h, input int v);
    sx = 10'(x); sy = 10'(y); de = d[0]; hs = h[0]; vs = v[0];
    pix_en = 1'b1;
    cycle();
    pix_en = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic show(input int x, input int y, input int d, output logic [11:0] got);
    strobe(x, y, d, 1, 1);
    strobe(x, y, d, 1, 1);
    got = {r, g, b};
  endtask

  task automatic vsync_start();
    strobe(0, 400, 0, 1, 1);
    strobe(0, 400, 0, 1, 0);
  endtask

  task automatic write_tile(input int a, input logic [11:0] c);
    wr_valid = 1'b1; wr_addr = 6'(a); wr_rgb = c;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  initial begin
    logic [11:0] got;
    int n;
    for (int i = 0; i < N; i++) begin m_bank[0][i] = '0; m_bank[1][i] = '0; end
    vecs[0]  = '{230, 150, 1, 0, 12'hF00};
    vecs[1]  = '{255, 175, 1, 1, 12'hF00};
    vecs[2]  = '{256, 150, 1, 0, 12'h000};
    vecs[3]  = '{100, 100, 1, 1, 12'h000};
    vecs[4]  = '{230, 150, 0, 1, 12'h000};
    vecs[5]  = '{192, 112, 1, 0, 12'h123};
    vecs[6]  = '{447, 367, 1, 1, 12'h5A5};
    vecs[7]  = '{448, 367, 1, 0, 12'h000};
    vecs[8]  = '{447, 368, 1, 1, 12'h000};
    vecs[9]  = '{191, 112, 1, 0, 12'h000};
    vecs[10] = '{224, 144, 1, 1, 12'hF00};

    rst_n = 1'b0; pix_en = 1'b0; sx = '0; sy = '0; de = 1'b0; hs = 1'b1; vs = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_rgb = '0; commit = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    chk("reset_rgb", {r, g, b}, 12'h000);
    chk("reset_hsync", ohs, 1'b1);
    chk("reset_vsync", ovs, 1'b1);
    chk("reset_wr_ready", wr_ready, 1'b1);
    chk("reset_pending", pending, 1'b0);
    chk("reset_frame_start", fstart, 1'b0);

    write_tile(9, 12'hF00);
    write_tile(0, 12'h123);
    write_tile(63, 12'h5A5);
    do_commit();
    chk("pending_after_commit", pending, 1'b1);
    show(230, 150, 1, got);
    chk("pre_swap_black", got, 12'h000);
    chk("pending_before_vsync", pending, 1'b1);
    strobe(0, 400, 0, 1, 1);
    sx = '0; sy = 10'd400; de = 1'b0; vs = 1'b0; pix_en = 1'b1;
    cycle();
    pix_en = 1'b0;
    n = 0;
    while (wr_ready === 1'b0 && n < 200) begin n++; cycle(); end
    chk("copy_busy_cycles", n, 64);
    chk("pending_after_swap", pending, 1'b0);

    for (int i = 0; i < 11; i++) begin
      strobe(vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].h, 1);
      strobe(vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].h, 1);
      chk($sformatf("vec%0d_rgb", i), {r, g, b}, vecs[i].rgb);
      chk($sformatf("vec%0d_hsync", i), ohs, vecs[i].h[0]);
    end

    strobe(300, 200, 1, 1, 1);
    strobe(300, 200, 1, 1, 1);
    strobe(300, 200, 1, 0, 1);
    chk("hsync_lag_one_strobe", ohs, 1'b1);
    strobe(300, 200, 1, 0, 1);
    chk("hsync_lag_two_strobes", ohs, 1'b0);

    write_tile(9, 12'h0F0);
    do_commit();
    vsync_start();
    repeat (70) cycle();
    show(230, 150, 1, got);
    chk("second_frame_tile9", got, 12'h0F0);
    show(192, 112, 1, got);
    chk("copied_tile0_kept", got, 12'h123);
    show(447, 367, 1, got);
    chk("copied_tile63_kept", got, 12'h5A5);

    wr_valid = 1'b1; wr_addr = 6'd63; wr_rgb = 12'hABC; commit = 1'b1;
    cycle();
    commit = 1'b0;
    repeat (3) cycle();
    chk("held_valid_not_ready", wr_ready, 1'b0);
    wr_valid = 1'b0;
    vsync_start();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
    n = 0;
    while (wr_ready === 1'b0 && n < 200) begin n++; cycle(); end
    repeat (2) cycle();
    chk("commit_in_copy_ignored", pending, 1'b0);
    show(447, 367, 1, got);
    chk("addr63_written", got, 12'hABC);

    for (int i = 0; i < 3000; i++) begin
      wr_valid = 1'($urandom);
      wr_addr = 6'($urandom);
      wr_rgb = 12'($urandom);
      commit = ($urandom_range(0, 39) == 0);
      pix_en = (i % 4 == 0);
      sx = 10'($urandom_range(150, 480));
      sy = 10'($urandom_range(80, 400));
      de = 1'($urandom);
      hs = 1'($urandom);
      if ($urandom_range(0, 15) == 0) vs = ~vs;
      cycle();
    end
    wr_valid = 1'b0; commit = 1'b0; pix_en = 1'b0;
    repeat (2) begin vsync_start(); repeat (70) cycle(); end

    write_tile(0, 12'h777);
    do_commit();
    vsync_start();
    // Land the reset exactly when the copy index reaches 20.
    n = 0;
    while (m_state == 2 && m_copy_idx < 20 && n < 200) begin n++; cycle(); end
    chk("copy_index_reached", m_copy_idx, 20);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_copy_reset_ready", wr_ready, 1'b1);
    chk("mid_copy_reset_pending", pending, 1'b0);
    show(192, 112, 1, got);
    chk("mid_copy_reset_tile0", got, 12'h777);
    show(447, 367, 1, got);
    chk("mid_copy_reset_tile63", got, colour(447, 367, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tile_frame_renderer.md
# tile_frame_renderer

Parametrised, double-buffered tile renderer: maps the display timing generator's pixel coordinates onto a GRID_W × GRID_H grid of solid-colour tiles and drives registered VGA RGB and syncs. Game logic writes tile colours through a valid/ready port into a back bank. A commit request swaps banks at the next vsync, then a copy engine re-synchronises the back bank. It sits between `display_480p` and the VGA pins, replacing the fixed 8×8 flat-array colour lookup.

## Interface
- `COORD_WIDTH`, 10, width of sx/sy
- `COLOR_BITS`, 4, bits per colour channel
- `GRID_W`, 8, tiles per row
- `GRID_H`, 8, tile rows
- `TILE_SHIFT`, 5, log2 of tile edge in pixels (32 px)
- `ORIGIN_X`, 192, left pixel of grid
- `ORIGIN_Y`, 112, top pixel of grid
- `BG_RGB`, 0, {r,g,b} shown in active area outside grid
- `SYNC_POL`, 0, active level of hsync/vsync
- `i_clk` in 1, system clock (100 MHz)
- `i_rst_n` in 1, synchronous active-low reset
- `i_pix_en` in 1, one-cycle pixel strobe (25 MHz rate)
- `i_sx`, `i_sy` in COORD_WIDTH, pixel coordinates from timing generator
- `i_de`, `i_hsync`, `i_vsync` in 1, timing generator outputs
- `i_wr_valid` in 1, tile write request
- `o_wr_ready` out 1, write accepted when valid && ready
- `i_wr_addr` in AW = clog2(GRID_W·GRID_H), tile index, row·GRID_W + col
- `i_wr_rgb` in 3·COLOR_BITS, {r,g,b}
- `i_commit` in 1, request bank swap
- `o_commit_pending` out 1, commit accepted, swap not yet done
- `o_frame_start` out 1, one-cycle pulse at each vsync start
- `o_r`, `o_g`, `o_b` out COLOR_BITS, VGA colour
- `o_hsync`, `o_vsync` out 1, delayed syncs

## Operation
- Two banks of GRID_W·GRID_H entries, each 3·COLOR_BITS wide. `front_sel` picks the display bank, and writes go to `!front_sel`. Both banks are zero at configuration and are not cleared by reset.
- Control FSM states:
  - IDLE: `o_wr_ready`=1. An accepted write updates the back bank. If `i_commit`=1, go to PENDING. A write accepted in the same cycle as the commit is included in the committed frame.
  - PENDING: `o_wr_ready`=0 and `o_commit_pending`=1. At vsync start, toggle `front_sel`, clear the copy counter and go to COPY.
  - COPY: `o_wr_ready`=0. One entry per `i_clk` cycle is copied, new front[k] → back[k], for k = 0..N−1. After entry N−1, go to IDLE. The copy takes exactly N cycles.
- `i_commit` in PENDING or COPY is ignored.
- Vsync start is a `i_pix_en` cycle where `i_vsync` changes from !SYNC_POL to SYNC_POL. `o_frame_start` pulses for that one `i_clk` cycle in every state.
- If `i_wr_addr` ≥ GRID_W·GRID_H, the handshake completes and the data is dropped.
- Pixel pipeline advances only on `i_pix_en`:
  - S1 registers the inside flag, the tile address, de and the syncs.
    - inside = sx ≥ ORIGIN_X && sx < ORIGIN_X + (GRID_W << TILE_SHIFT), with the same test on y.
    - addr = ((sy−ORIGIN_Y) >> TILE_SHIFT)·GRID_W + ((sx−ORIGIN_X) >> TILE_SHIFT).
  - S2 performs a synchronous read of the front bank and registers the outputs.
    - RGB = inside ? tile : BG_RGB when de=1, otherwise 0.
- The swap happens during vsync, so no visible frame ever mixes banks.

## Timing
- Reset: state IDLE, `front_sel`=0, copy counter 0, `o_wr_ready`=1, `o_commit_pending`=0, `o_frame_start`=0, RGB 0, syncs at !SYNC_POL, pipeline de=0.
- Reset during COPY or PENDING aborts the operation, and the swap is undone because `front_sel` returns to 0.
- Pixel path latency is exactly 2 `i_pix_en` strobes from inputs to `o_r/g/b/hsync/vsync`. Syncs and colour stay aligned.
- Outputs hold their value between strobes.
- A write accepted at cycle t is readable by the copy engine from t+1.
- Commit → swap: at the first vsync start after entering PENDING. Swap → IDLE: N `i_clk` cycles, which is 64 for the default grid and well inside vblank.

## Test plan
- Reset with `i_rst_n`=0 for 3 cycles → RGB=0, syncs=1 (SYNC_POL=0), `o_wr_ready`=1, `o_commit_pending`=0.
- Write tile 9 = 12'hF00, commit, run one frame → before the swap, pixel (230,150) shows black. After the swap, the next frame shows r=F, g=0, b=0 at (230,150) and (255,175). Pixel (256,150), which is tile 10, stays 0.
- Commit then check timing → `o_commit_pending`=1 until the vsync start. `o_wr_ready`=0 for exactly 64 cycles after the swap. After COPY, both banks hold tile 9 = F00 (verified by writing tile 9 = 0F0, committing, and checking the previous colours elsewhere remain).
- De/border check → pixel (100,100) with de=1 shows BG_RGB. Any pixel with de=0 shows 0. The sync edge at the output lags the input by exactly 2 strobes.
- Write to addr 63 with valid held across a commit, plus a second `i_commit` during COPY → addr 63 is written once, exactly one swap occurs, and the second commit is ignored.
- Assert reset mid-COPY, at copy index 20 → next cycle state IDLE, `front_sel`=0, `o_wr_ready`=1; display shows bank 0.
